// File: rtl/clk_slot_arbiter_if.sv
// Request/grant bundle between the slot arbiter and its requesters.
// Clock and reset stay plain ports on the arbiter itself.
interface clk_slot_arbiter_if #(
  parameter int NREQ = 4
);
  logic                iEn;
  logic [2*NREQ-1:0]   iRateSel;
  logic [NREQ-1:0]     iReq;
  logic                iDone;
  logic                iClrMissed;
  logic [NREQ-1:0]     oGnt;
  logic                oBusy;
  logic [3:0]          oPhase;
  logic [NREQ-1:0]     oMissed;
  logic                oTimeout;

  modport master (
    output iEn, iRateSel, iReq, iDone, iClrMissed,
    input  oGnt, oBusy, oPhase, oMissed, oTimeout
  );

  modport slave (
    input  iEn, iRateSel, iReq, iDone, iClrMissed,
    output oGnt, oBusy, oPhase, oMissed, oTimeout
  );
endinterface

// File: rtl/clk_slot_arbiter.sv
// Divided-rate slot arbiter: phase-counter strobes open slots, round-robin FSM grants one requester.
// Define GNT_TIMEOUT_EN to add the grant watchdog that aborts a grant after TIMEOUT cycles.
module clk_slot_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              iClkIN,
  input  logic              reset,
  clk_slot_arbiter_if.slave bus
);
  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_q, state_d;
  logic [3:0]      phase_q, phase_d;
  logic [NREQ-1:0] pend_q, pend_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] missed_q, missed_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [IDXW-1:0] gidx_q, gidx_d;
  logic            tmo_q, tmo_d;

  logic [3:0]      strobe;
  logic [NREQ-1:0] capture;
  logic [NREQ-1:0] retire;
  logic            abort;
  logic            pick_found;
  logic [IDXW-1:0] pick_idx;
  logic [IDXW-1:0] cand;
  int              k;

`ifdef GNT_TIMEOUT_EN
  localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT - 1);
  logic [7:0] wd_q, wd_d;
`else
  // Watchdog absent: the parameter stays so both builds share one port map.
  logic [31:0] timeout_unused;
  assign timeout_unused = 32'(TIMEOUT);
`endif

  // Rate strobes: strobe[r] fires when the low r+1 phase bits are all ones.
  always_comb begin
    strobe    = '0;
    strobe[0] = bus.iEn & phase_q[0];
    strobe[1] = bus.iEn & (&phase_q[1:0]);
    strobe[2] = bus.iEn & (&phase_q[2:0]);
    strobe[3] = bus.iEn & (&phase_q[3:0]);
  end

  always_comb begin
    capture = '0;
    for (int i = 0; i < NREQ; i++) begin
      capture[i] = bus.iReq[i] & strobe[bus.iRateSel[2*i +: 2]];
    end
  end

  // First pending requester at or after the pointer, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = ptr_q;
    cand       = '0;
    k          = 0;
    for (int j = 0; j < NREQ; j++) begin
      k = int'(ptr_q) + j;
      if (k >= NREQ) k = k - NREQ;
      cand = IDXW'(k);
      if (!pick_found && pend_q[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    retire  = '0;
    abort   = 1'b0;
`ifdef GNT_TIMEOUT_EN
    wd_d    = (state_q == BUSY) ? wd_q + 8'd1 : 8'd0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d          = BUSY;
          gnt_d            = '0;
          gnt_d[pick_idx]  = 1'b1;
          gidx_d           = pick_idx;
        end
      end
      BUSY: begin
`ifdef GNT_TIMEOUT_EN
        abort = !bus.iDone && (wd_q == WD_LIMIT);
`endif
        if (bus.iDone || abort) begin
          retire  = gnt_q;
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = (gidx_q == IDXW'(NREQ - 1)) ? '0 : gidx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A new capture beats a same-edge retirement; a new miss beats a same-edge clear.
  always_comb begin
    pend_d   = (pend_q & ~retire) | capture;
    missed_d = (bus.iClrMissed ? '0 : missed_q)
             | (capture & pend_q & ~retire)
             | (abort ? gnt_q : '0);
    phase_d  = bus.iEn ? phase_q + 4'd1 : phase_q;
    tmo_d    = abort;
  end

  always_ff @(posedge iClkIN or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      pend_q   <= '0;
      gnt_q    <= '0;
      missed_q <= '0;
      ptr_q    <= '0;
      gidx_q   <= '0;
      tmo_q    <= 1'b0;
`ifdef GNT_TIMEOUT_EN
      wd_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      pend_q   <= pend_d;
      gnt_q    <= gnt_d;
      missed_q <= missed_d;
      ptr_q    <= ptr_d;
      gidx_q   <= gidx_d;
      tmo_q    <= tmo_d;
`ifdef GNT_TIMEOUT_EN
      wd_q     <= wd_d;
`endif
    end
  end

  assign bus.oGnt     = gnt_q;
  assign bus.oBusy    = (state_q == BUSY);
  assign bus.oPhase   = phase_q;
  assign bus.oMissed  = missed_q;
`ifdef GNT_TIMEOUT_EN
  assign bus.oTimeout = tmo_q;
`else
  assign bus.oTimeout = 1'b0;
`endif

endmodule

// File: tb/tb_clk_slot_arbiter.sv
// Self-checking bench for clk_slot_arbiter: directed table, hand sequences, random vs. reference model.
module tb_clk_slot_arbiter;
  localparam int NREQ = 4;
`ifdef GNT_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 64;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  clk_slot_arbiter_if #(.NREQ(NREQ)) bus ();
  clk_slot_arbiter #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
    .iClkIN (clk),
    .reset  (rst_n),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: slot/arbitration rules expressed with plain integers and arrays.
  int m_ph, m_gidx, m_ptr, m_age;
  bit m_pend[NREQ];
  bit m_mis[NREQ];
  bit m_tmo;

  function automatic void model_reset();
    m_ph = 0; m_gidx = -1; m_ptr = 0; m_age = 0; m_tmo = 1'b0;
    for (int i = 0; i < NREQ; i++) begin m_pend[i] = 1'b0; m_mis[i] = 1'b0; end
  endfunction

  task automatic model_step(input bit en, input logic [7:0] rs, input logic [3:0] req,
                            input bit done, input bit clr);
    int retire, period, idx;
    bit tmo_n, found;
    bit pend_n[NREQ];
    bit mis_n[NREQ];
    retire = -1; tmo_n = 1'b0; found = 1'b0;
    if (m_gidx >= 0) begin
      if (done) retire = m_gidx;
`ifdef GNT_TIMEOUT_EN
      else if (m_age == TMO - 1) begin retire = m_gidx; tmo_n = 1'b1; end
`endif
    end
    for (int i = 0; i < NREQ; i++) begin
      period   = 2 << int'(rs[2*i +: 2]);
      pend_n[i] = m_pend[i] && (i != retire);
      mis_n[i]  = clr ? 1'b0 : m_mis[i];
      if (en && req[i] && ((m_ph + 1) % period == 0)) begin
        if (m_pend[i] && i != retire) mis_n[i] = 1'b1;
        pend_n[i] = 1'b1;
      end
      if (tmo_n && i == retire) mis_n[i] = 1'b1;
    end
    if (m_gidx < 0) begin
      for (int j = 0; j < NREQ; j++) begin
        idx = (m_ptr + j) % NREQ;
        if (!found && m_pend[idx]) begin found = 1'b1; m_gidx = idx; m_age = 0; end
      end
    end else if (retire >= 0) begin
      m_ptr  = (retire + 1) % NREQ;
      m_gidx = -1;
    end else begin
      m_age++;
    end
    m_tmo = tmo_n;
    for (int i = 0; i < NREQ; i++) begin m_pend[i] = pend_n[i]; m_mis[i] = mis_n[i]; end
    m_ph = en ? (m_ph + 1) % 16 : m_ph;
  endtask

  function automatic logic [3:0] m_gnt_vec();
    logic [3:0] v;
    v = 4'h0;
    if (m_gidx >= 0) v[m_gidx] = 1'b1;
    return v;
  endfunction

  function automatic logic [3:0] m_mis_vec();
    logic [3:0] v;
    for (int i = 0; i < NREQ; i++) v[i] = m_mis[i];
    return v;
  endfunction

  task automatic compare_model();
    check("model_gnt",     32'(bus.oGnt),     32'(m_gnt_vec()));
    check("model_busy",    32'(bus.oBusy),    32'(m_gidx >= 0));
    check("model_phase",   32'(bus.oPhase),   32'(m_ph));
    check("model_missed",  32'(bus.oMissed),  32'(m_mis_vec()));
    check("model_timeout", 32'(bus.oTimeout), 32'(m_tmo));
  endtask

  // One clock: drive inputs, advance model, sample 1 time unit after the edge.
  task automatic cycle(input bit en, input logic [7:0] rs, input logic [3:0] req,
                       input bit done, input bit clr);
    bus.iEn = en; bus.iRateSel = rs; bus.iReq = req; bus.iDone = done; bus.iClrMissed = clr;
    model_step(en, rs, req, done, clr);
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.iEn = 1'b0; bus.iRateSel = '0; bus.iReq = '0; bus.iDone = 1'b0; bus.iClrMissed = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_gnt",     32'(bus.oGnt),     32'h0);
    check("reset_busy",    32'(bus.oBusy),    32'h0);
    check("reset_phase",   32'(bus.oPhase),   32'h0);
    check("reset_missed",  32'(bus.oMissed),  32'h0);
    check("reset_timeout", 32'(bus.oTimeout), 32'h0);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit         en;
    logic [7:0] rs;
    logic [3:0] req;
    bit         done;
    bit         clr;
    logic [3:0] gnt;
    bit         busy;
    logic [3:0] ph;
    logic [3:0] mis;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int n;
    bit en_r;
    logic [7:0] rs_r;
    logic [3:0] req_r;
    bit done_r, clr_r;

    // Requester 0 at /2, grant held, overrun, same-edge retire+capture, clear vs. new miss.
    tbl[0]  = '{1'b1, 8'h00, 4'h1, 1'b0, 1'b0, 4'h0, 1'b0, 4'd1,  4'h0};
    tbl[1]  = '{1'b1, 8'h00, 4'h1, 1'b0, 1'b0, 4'h0, 1'b0, 4'd2,  4'h0};
    tbl[2]  = '{1'b1, 8'h00, 4'h1, 1'b0, 1'b0, 4'h1, 1'b1, 4'd3,  4'h0};
    tbl[3]  = '{1'b1, 8'h00, 4'h1, 1'b0, 1'b0, 4'h1, 1'b1, 4'd4,  4'h1};
    tbl[4]  = '{1'b1, 8'h00, 4'h1, 1'b0, 1'b0, 4'h1, 1'b1, 4'd5,  4'h1};
    tbl[5]  = '{1'b1, 8'h00, 4'h1, 1'b1, 1'b0, 4'h0, 1'b0, 4'd6,  4'h1};
    tbl[6]  = '{1'b1, 8'h00, 4'h1, 1'b0, 1'b1, 4'h1, 1'b1, 4'd7,  4'h0};
    tbl[7]  = '{1'b1, 8'h00, 4'h1, 1'b0, 1'b1, 4'h1, 1'b1, 4'd8,  4'h1};
    tbl[8]  = '{1'b1, 8'h00, 4'h0, 1'b0, 1'b1, 4'h1, 1'b1, 4'd9,  4'h0};
    tbl[9]  = '{1'b1, 8'h00, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 4'd10, 4'h0};
    tbl[10] = '{1'b1, 8'h00, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 4'd11, 4'h0};

    // Phase counts and wraps with no requests, then holds with iEn=0.
    do_reset();
    for (int c = 0; c < 17; c++) begin
      cycle(1'b1, 8'h00, 4'h0, 1'b0, 1'b0);
      check("phase_count", 32'(bus.oPhase), 32'((c + 1) % 16));
      check("phase_idle_gnt", 32'({bus.oGnt, bus.oBusy}), 32'h0);
    end
    for (int c = 0; c < 2; c++) begin
      cycle(1'b0, 8'h00, 4'hF, 1'b0, 1'b0);
      check("phase_hold", 32'(bus.oPhase), 32'd1);
    end

    do_reset();
    for (int v = 0; v < 11; v++) begin
      cycle(tbl[v].en, tbl[v].rs, tbl[v].req, tbl[v].done, tbl[v].clr);
      check("tbl_gnt",    32'(bus.oGnt),    32'(tbl[v].gnt));
      check("tbl_busy",   32'(bus.oBusy),   32'(tbl[v].busy));
      check("tbl_phase",  32'(bus.oPhase),  32'(tbl[v].ph));
      check("tbl_missed", 32'(bus.oMissed), 32'(tbl[v].mis));
    end

    // All /16, all requesting: two frames of round-robin 0,1,2,3 with no overruns.
    do_reset();
    for (int f = 0; f < 2; f++) begin
      for (int r = 0; r < NREQ; r++) begin
        n = 0;
        while (bus.oGnt == 4'h0 && n < 40) begin
          cycle(1'b1, 8'hFF, 4'hF, 1'b0, 1'b0);
          n++;
        end
        check("rr_wait_bounded", 32'(n < 40), 32'd1);
        check("rr_order", 32'(bus.oGnt), 32'(4'h1 << r));
        if (r == 0) check("rr_frame_phase", 32'(bus.oPhase), 32'd1);
        cycle(1'b1, 8'hFF, 4'hF, 1'b0, 1'b0);
        cycle(1'b1, 8'hFF, 4'hF, 1'b1, 1'b0);
        check("rr_release", 32'(bus.oGnt), 32'h0);
      end
    end
    check("rr_missed", 32'(bus.oMissed), 32'h0);

    // Requester 1 at /4: iDone on the edge of its next strobe keeps it pending.
    do_reset();
    for (int c = 0; c < 4; c++) cycle(1'b1, 8'h04, 4'h2, 1'b0, 1'b0);
    check("same_edge_pre", 32'(bus.oGnt), 32'h0);
    cycle(1'b1, 8'h04, 4'h2, 1'b0, 1'b0);
    check("same_edge_gnt", 32'(bus.oGnt), 32'h2);
    cycle(1'b1, 8'h04, 4'h2, 1'b0, 1'b0);
    cycle(1'b1, 8'h04, 4'h2, 1'b0, 1'b0);
    cycle(1'b1, 8'h04, 4'h2, 1'b1, 1'b0);
    check("same_edge_drop", 32'({bus.oGnt, bus.oBusy}), 32'h0);
    check("same_edge_missed", 32'(bus.oMissed), 32'h0);
    cycle(1'b1, 8'h04, 4'h2, 1'b0, 1'b0);
    check("same_edge_regnt", 32'(bus.oGnt), 32'h2);
    check("same_edge_missed2", 32'(bus.oMissed), 32'h0);
    cycle(1'b1, 8'h04, 4'h0, 1'b1, 1'b0);
    check("same_edge_done", 32'(bus.oGnt), 32'h0);

    // Async reset mid-grant with the pointer moved away from 0.
    do_reset();
    cycle(1'b1, 8'h00, 4'h6, 1'b0, 1'b0);
    cycle(1'b1, 8'h00, 4'h6, 1'b0, 1'b0);
    cycle(1'b1, 8'h00, 4'h0, 1'b0, 1'b0);
    check("arst_first_gnt", 32'(bus.oGnt), 32'h2);
    cycle(1'b1, 8'h00, 4'h0, 1'b1, 1'b0);
    cycle(1'b1, 8'h00, 4'h0, 1'b0, 1'b0);
    check("arst_gnt2", 32'(bus.oGnt), 32'h4);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_gnt_drop",  32'(bus.oGnt),  32'h0);
    check("arst_busy_drop", 32'(bus.oBusy), 32'h0);
    model_reset();
    bus.iReq = '0; bus.iDone = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 8'h00, 4'h9, 1'b0, 1'b0);
    cycle(1'b1, 8'h00, 4'h9, 1'b0, 1'b0);
    cycle(1'b1, 8'h00, 4'h0, 1'b0, 1'b0);
    check("arst_ptr_zero", 32'(bus.oGnt), 32'h1);
    cycle(1'b1, 8'h00, 4'h0, 1'b1, 1'b0);

`ifdef GNT_TIMEOUT_EN
    // Watchdog: iDone never comes; abort 8 edges after the grant, next requester follows.
    do_reset();
    cycle(1'b1, 8'h00, 4'h3, 1'b0, 1'b0);
    cycle(1'b1, 8'h00, 4'h3, 1'b0, 1'b0);
    cycle(1'b1, 8'h00, 4'h0, 1'b0, 1'b0);
    check("wd_gnt", 32'(bus.oGnt), 32'h1);
    for (int c = 0; c < 7; c++) begin
      cycle(1'b1, 8'h00, 4'h0, 1'b0, 1'b0);
      check("wd_quiet", 32'(bus.oTimeout), 32'h0);
    end
    cycle(1'b1, 8'h00, 4'h0, 1'b0, 1'b0);
    check("wd_pulse",  32'(bus.oTimeout), 32'h1);
    check("wd_drop",   32'(bus.oGnt),     32'h0);
    check("wd_missed", 32'(bus.oMissed),  32'h1);
    cycle(1'b1, 8'h00, 4'h0, 1'b0, 1'b0);
    check("wd_pulse_end", 32'(bus.oTimeout), 32'h0);
    check("wd_next_gnt",  32'(bus.oGnt),     32'h2);
    cycle(1'b1, 8'h00, 4'h0, 1'b1, 1'b0);
`endif

    // Randomized traffic checked every cycle against the model.
    do_reset();
    rs_r = 8'($urandom);
    for (int c = 0; c < 3000; c++) begin
      en_r  = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0) rs_r = 8'($urandom);
      req_r = 4'($urandom);
      done_r = (m_gidx >= 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
      clr_r = ($urandom_range(0, 31) == 0);
      cycle(en_r, rs_r, req_r, done_r, clr_r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench did not finish");
  end

endmodule
